// File: rtl/hdc_pkg.sv
// hdc_pkg: FSM states and sizing helpers shared by the hdc_inference_engine files
package hdc_pkg;
    typedef enum logic [1:0] {ACCUM, SEARCH, DONE} state_t;

    function automatic int dist_w(input int dim);
        return $clog2(dim + 1);
    endfunction

    function automatic int beats(input int dim, input int chunk);
        return (dim + chunk - 1) / chunk;
    endfunction

    // Number of live bits in the final beat; the rest of that beat is masked off.
    function automatic int last_bits(input int dim, input int chunk);
        return dim - (beats(dim, chunk) - 1) * chunk;
    endfunction
endpackage

// File: rtl/hdc_if.sv
// hdc_if: beat input stream and classification result stream of hdc_inference_engine
interface hdc_if import hdc_pkg::*; #(
    parameter int DIM = 10000,
    parameter int CHUNK = 64,
    parameter int NUM_CLASSES = 2
);
    localparam int DIST_W = dist_w(DIM);

    logic in_valid;
    logic in_ready;
    logic [CHUNK-1:0] in_query;
    logic [NUM_CLASSES*CHUNK-1:0] in_class;
    logic out_valid;
    logic out_ready;
    logic [$clog2(NUM_CLASSES)-1:0] out_class;
    logic [DIST_W-1:0] out_dist;
    logic out_tie;
    logic [DIST_W-1:0] out_margin;

    modport master (
        output in_valid, in_query, in_class, out_ready,
        input  in_ready, out_valid, out_class, out_dist, out_tie, out_margin
    );
    modport slave (
        input  in_valid, in_query, in_class, out_ready,
        output in_ready, out_valid, out_class, out_dist, out_tie, out_margin
    );
endinterface

// File: rtl/hdc_popcount.sv
// hdc_popcount: combinational population count of a W-bit word
module hdc_popcount #(
    parameter int W = 64
) (
    input  logic [W-1:0] d,
    output logic [$clog2(W+1)-1:0] cnt
);
    localparam int CW = $clog2(W + 1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt += CW'(d[i]);
    end
endmodule

// File: rtl/hdc_inference_engine.sv
// hdc_inference_engine: streaming Hamming-distance classifier; HDC_MARGIN_EN builds the second-best margin path
module hdc_inference_engine import hdc_pkg::*; #(
    parameter int DIM = 10000,
    parameter int CHUNK = 64,
    parameter int NUM_CLASSES = 2
) (
    input logic clk,
    input logic rst,
    hdc_if.slave bus
);
    localparam int DIST_W = dist_w(DIM);
    localparam int BEATS = beats(DIM, CHUNK);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int IW = $clog2(NUM_CLASSES);
    localparam int CW = $clog2(CHUNK + 1);
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - last_bits(DIM, CHUNK));

    state_t state, state_n;
    logic [BW-1:0] beat_cnt;
    logic [IW-1:0] idx;
    logic [DIST_W-1:0] acc [NUM_CLASSES];
    logic [CW-1:0] pc [NUM_CLASSES];
    logic [IW-1:0] best_idx;
    logic [DIST_W-1:0] best;
    logic tie;
    logic take, last_beat, last_idx;
    logic [DIST_W-1:0] cur;

    assign take = bus.in_valid && state == ACCUM;
    assign last_beat = beat_cnt == BW'(BEATS - 1);
    assign last_idx = idx == IW'(NUM_CLASSES - 1);
    assign cur = acc[idx];

    genvar c;
    for (c = 0; c < NUM_CLASSES; c++) begin : g_pc
        hdc_popcount #(.W(CHUNK)) u_pc (
            .d((bus.in_query ^ bus.in_class[c*CHUNK +: CHUNK]) & (last_beat ? LAST_MASK : {CHUNK{1'b1}})),
            .cnt(pc[c])
        );
    end

    always_ff @(posedge clk) state <= rst ? ACCUM : state_n;

    always_comb begin
        state_n = state;
        if (state == ACCUM && take && last_beat) state_n = SEARCH;
        if (state == SEARCH && last_idx) state_n = DONE;
        if (state == DONE && bus.out_ready) state_n = ACCUM;
        bus.in_ready = state == ACCUM && !rst;
        bus.out_valid = state == DONE;
    end

    // Linear scan, one class per cycle; strict less-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            idx <= '0;
            best_idx <= '0;
            best <= '0;
            tie <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
        end else begin
            if (take) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
                for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= acc[i] + DIST_W'(pc[i]);
            end
            if (state == SEARCH) begin
                idx <= last_idx ? '0 : idx + IW'(1);
                if (idx == '0 || cur < best) begin
                    best_idx <= idx;
                    best <= cur;
                end
                tie <= idx == '0 ? 1'b0 : cur < best ? 1'b0 : cur == best ? 1'b1 : tie;
            end
            if (state == DONE && bus.out_ready)
                for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
        end
    end

`ifdef HDC_MARGIN_EN
    logic [DIST_W-1:0] second;

    always_ff @(posedge clk) begin
        if (rst) second <= '0;
        else if (state == SEARCH) second <= idx == '0 ? '1 : cur < best ? best : cur < second ? cur : second;
    end

    assign bus.out_margin = second - best;
`else
    assign bus.out_margin = '0;
`endif

    assign bus.out_class = best_idx;
    assign bus.out_dist = best;
    assign bus.out_tie = tie;
endmodule

// File: doc/hdc_inference_engine.md
# hdc_inference_engine

Parametrised hyperdimensional inference engine. It streams a binary query hypervector and NUM_CLASSES binary class hypervectors in CHUNK-bit beats, and accumulates one Hamming distance per class. When the last beat is in, it selects the closest class and reports its index, distance, tie flag and optional confidence margin. It sits between the encoder/class-memory read path and the classification result consumer.

## Interface
- DIM, 10000, hypervector length in bits (>= 1)
- CHUNK, 64, bits per beat (>= 1)
- NUM_CLASSES, 2, number of class hypervectors (>= 2)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_query  input  CHUNK  query bits for this beat; bit 0 = lowest HV index
- in_class  input  NUM_CLASSES*CHUNK  class c chunk at [c*CHUNK +: CHUNK]
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_class  output  $clog2(NUM_CLASSES)  index of minimum distance
- out_dist  output  DIST_W = $clog2(DIM+1)  Hamming distance of winner
- out_tie  output  1  another class has the same minimum distance
- out_margin  output  DIST_W  second-smallest minus smallest distance

## Operation
- BEATS = ceil(DIM/CHUNK). The final beat uses only the low DIM - (BEATS-1)*CHUNK bits; the remaining bits are masked and never counted.
- ACCUM state:
  - in_ready = 1.
  - On each accepted beat, acc[c] += popcount(in_query ^ class_c_chunk) for every class c in parallel.
  - beat_cnt increments on each accepted beat.
  - Bubbles (in_valid low) do not change any state.
- On acceptance of beat BEATS-1: beat_cnt wraps to 0 and the FSM goes to SEARCH.
- SEARCH state:
  - in_ready = 0.
  - The block scans one class per cycle, c = 0..NUM_CLASSES-1, tracking best index, best distance and second-best distance.
  - Strictly-less comparison, so ties resolve to the lowest index.
  - out_tie is set if any later class equals the running best.
  - After the last class, the FSM goes to DONE.
- DONE state:
  - out_valid = 1 and in_ready = 0.
  - Outputs are held stable until out_ready.
  - On handshake, all acc[c] are cleared and the FSM returns to ACCUM.
- Arithmetic:
  - Accumulators are DIST_W bits and cannot overflow, since the maximum is DIM.
  - Margin = second - best, unsigned; it is 0 whenever out_tie = 1.
- Reset (any state, including mid-vector or while out_valid is high): the FSM goes to ACCUM, beat_cnt = 0, all acc = 0, and partial results are discarded.
- Reset values: in_ready = 0 during the reset cycle and 1 the cycle after. out_valid, out_class, out_dist, out_tie and out_margin are all 0.

## Timing
- A beat accepted at edge T is reflected in acc at T+1.
- Last beat accepted at edge T: SEARCH occupies cycles T+1..T+NUM_CLASSES, and out_valid rises at T+NUM_CLASSES+1.
- The earliest next beat is accepted in the cycle after the output handshake.
- Throughput: one vector per BEATS + NUM_CLASSES + 1 cycles, with no backpressure.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- HDC_MARGIN_EN:
  - Defined: second-best tracking and the margin subtractor are built, and out_margin is as specified.
  - Undefined: the second-best logic is omitted and out_margin is tied to 0.
  - out_class, out_dist and out_tie behave identically in both builds.

## Structure
- Package hdc_pkg holds:
  - the FSM state enum (ACCUM, SEARCH, DONE);
  - the helper functions for DIST_W and BEATS;
  - the last-beat mask computation.
- Sub-module hdc_popcount: combinational CHUNK-bit popcount with a $clog2(CHUNK+1)-bit output, instantiated NUM_CLASSES times.

## Test plan
DIM=256, CHUNK=64, NUM_CLASSES=4 unless stated.
- Distinct distances:
  - Stimulus: query all 0; class0 all 0; class1 all 1; class2 0x5555…; class3 0x00FF… per beat.
  - Response: out_class=0, out_dist=0, out_tie=0, out_margin=128.
- Tie:
  - Stimulus: class1 and class2 each differ from the query in 10 bits; class0 and class3 differ in 50 bits.
  - Response: out_class=1, out_dist=10, out_tie=1, out_margin=0.
- Partial last beat:
  - Stimulus: DIM=200; bits [63:8] of the final beat differ for every class; all counted bits match for class2.
  - Response: out_class=2, out_dist=0; the result arrives after 4 beats.
- Backpressure and latency:
  - Stimulus: hold out_ready low for 5 cycles.
  - Response: out_valid rises exactly 5 cycles after the last beat; outputs stay constant; in_ready stays 0 until the handshake.
- Bubbles:
  - Stimulus: insert 3 idle cycles between each beat of the first-scenario vector.
  - Response: identical result.
- Reset mid-vector:
  - Stimulus: assert rst after 2 beats, then send the full first-scenario vector.
  - Response: in_ready=1 the cycle after reset; result out_class=0, out_dist=0, with no leftover counts from the partial vector.
